// File: rtl/dmem_mmio_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder_if
// Bundles the core data port and the TX byte stream of dmem_mmio_responder.
//   MemWrite    core -> responder   store strobe
//   Mem_WrAddr  core -> responder   byte address for loads and stores
//   Mem_WrData  core -> responder   store data
//   ReadData    responder -> core   combinational load data
//   led         responder -> pins   LED register
//   irq         responder -> core   timer flag
//   tx_data     responder -> sink   FIFO head byte (0 when empty)
//   tx_valid    responder -> sink   FIFO not empty
//   tx_ready    sink -> responder   byte accepted when tx_valid && tx_ready
// -----------------------------------------------------------------------------
interface dmem_mmio_responder_if;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic [31:0] ReadData;
   logic [7:0]  led;
   logic        irq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   // Core / environment side
   modport master (
      output MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
      input  ReadData, led, irq, tx_data, tx_valid
   );

   // Responder side
   modport slave (
      input  MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
      output ReadData, led, irq, tx_data, tx_valid
   );
endinterface

// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
// Data-side responder for a single-cycle RISC-V core. Address bit 31 selects
// a word RAM (0) or an MMIO block (1) holding an LED register, a free-running
// cycle counter with compare/flag, and a byte TX FIFO drained over valid/ready.
// Loads are combinational and side-effect free; all state changes on clk.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high reset (RAM contents are kept)
//   bus    dmem_mmio_responder_if.slave: core data port + TX stream
// Parameters:
//   RAM_WORDS   RAM depth in 32-bit words (power of 2)
//   FIFO_DEPTH  TX FIFO depth in bytes (power of 2, >= 2)
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   dmem_mmio_responder_if.slave   bus
);

   localparam int RAM_AW  = $clog2(RAM_WORDS);
   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int CW      = FIFO_AW + 1;

   // MMIO word offsets (address bits [4:2])
   localparam logic [2:0] OFF_LED    = 3'd0;
   localparam logic [2:0] OFF_CYCLE  = 3'd1;
   localparam logic [2:0] OFF_CMP    = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_TXDATA = 3'd4;

   // ---------------------------------------------------------------- decode
   logic              w_is_mmio;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [2:0]        w_off;
   logic              w_ram_we;
   logic              w_mmio_we;
   logic              w_unused;

   assign w_is_mmio = bus.Mem_WrAddr[31];
   assign w_ram_idx = bus.Mem_WrAddr[RAM_AW+1:2];
   assign w_off     = bus.Mem_WrAddr[4:2];
   assign w_ram_we  = bus.MemWrite & ~w_is_mmio;
   assign w_mmio_we = bus.MemWrite &  w_is_mmio;
   // Byte-lane bits and the aliased upper address bits are don't-care.
   assign w_unused  = ^bus.Mem_WrAddr[30:0];

   // ------------------------------------------------------------------- RAM
   // Not reset: contents survive a reset pulse.
   logic [31:0] r_ram [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_ram[w_ram_idx] <= bus.Mem_WrData;
   end

   // ------------------------------------------------------------ MMIO state
   logic [7:0]         r_led;
   logic [31:0]        r_cycle;
   logic [31:0]        r_cmp;
   logic               r_tflag;
   logic [7:0]         r_fifo [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW-1:0] r_wptr;
   logic [CW-1:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push_req;
   logic w_push;
   logic w_match;
   logic w_w1c;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_pop      = ~w_empty & bus.tx_ready;
   assign w_push_req = w_mmio_we & (w_off == OFF_TXDATA);
   // A push into a full FIFO only lands if a pop frees a slot this cycle.
   assign w_push     = w_push_req & (~w_full | w_pop);
   // Compare uses the pre-increment counter and the pre-write CMP.
   assign w_match    = (r_cycle == r_cmp);
   assign w_w1c      = w_mmio_we & (w_off == OFF_STATUS) & bus.Mem_WrData[0];

   // FIFO storage is not reset; a write racing a reset is invisible because
   // the pointers and count return to empty.
   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo[r_wptr] <= bus.Mem_WrData[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led   <= '0;
         r_cycle <= '0;
         r_cmp   <= 32'hFFFF_FFFF;
         r_tflag <= 1'b0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;

         if (w_mmio_we && (w_off == OFF_LED))
            r_led <= bus.Mem_WrData[7:0];
         if (w_mmio_we && (w_off == OFF_CMP))
            r_cmp <= bus.Mem_WrData;

         // Set has priority over a same-cycle clear.
         if (w_match)
            r_tflag <= 1'b1;
         else if (w_w1c)
            r_tflag <= 1'b0;

         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------ read mux
   logic [31:0] w_status;
   logic [31:0] w_mmio_rd;

   assign w_status = 32'({r_count, w_empty, w_full, r_tflag});

   always_comb begin
      w_mmio_rd = '0;
      case (w_off)
         OFF_LED:    w_mmio_rd = {24'd0, r_led};
         OFF_CYCLE:  w_mmio_rd = r_cycle;
         OFF_CMP:    w_mmio_rd = r_cmp;
         OFF_STATUS: w_mmio_rd = w_status;
         default:    w_mmio_rd = '0;
      endcase
   end

   assign bus.ReadData = w_is_mmio ? w_mmio_rd : r_ram[w_ram_idx];
   assign bus.led      = r_led;
   assign bus.irq      = r_tflag;
   assign bus.tx_valid = ~w_empty;
   assign bus.tx_data  = w_empty ? 8'd0 : r_fifo[r_rptr];

endmodule
